// File: rtl/ram_bus_arbiter_if.sv
// Requester-side and RAMControl-side signals of the shared RAM port.
// The slave modport is the arbiter's view; the master modport is the requesters plus RAMControl.
interface ram_bus_arbiter_if #(
    parameter int NREQ = 3
);
    logic [NREQ-1:0]      req;
    logic [NREQ-1:0]      req_we;
    logic [NREQ*23-1:0]   req_addr;
    logic [NREQ*16-1:0]   req_wdata;
    logic [NREQ-1:0]      gnt;
    logic [NREQ-1:0]      done;
    logic [15:0]          rdata;
    logic                 ram_instr;
    logic                 ram_latch;
    logic [22:0]          ram_addr;
    logic [15:0]          ram_wdata;
    logic [15:0]          ram_rdata;
    logic                 ram_ready;

    modport slave (
        input  req, req_we, req_addr, req_wdata, ram_rdata, ram_ready,
        output gnt, done, rdata, ram_instr, ram_latch, ram_addr, ram_wdata
    );

    modport master (
        output req, req_we, req_addr, req_wdata, ram_rdata, ram_ready,
        input  gnt, done, rdata, ram_instr, ram_latch, ram_addr, ram_wdata
    );
endinterface

// File: rtl/ram_bus_arbiter.sv
// Round-robin arbiter sharing one RAMControl port among NREQ masters, with
// per-master bursts and a busy-acknowledge timeout. All outputs are registered.
module ram_bus_arbiter #(
    parameter int NREQ         = 3,
    parameter int MAX_BURST    = 1,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    ram_bus_arbiter_if.slave   bus,
    output logic               timeout_err
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST + 1) : 1;
    localparam int TW = $clog2(BUSY_TIMEOUT + 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_ISSUE     = 3'd1;
    localparam logic [2:0] S_WAIT_BUSY = 3'd2;
    localparam logic [2:0] S_WAIT_DONE = 3'd3;
    localparam logic [2:0] S_DONE      = 3'd4;

    logic [2:0]      state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] done_q, done_d;
    logic            latch_q, latch_d;
    logic            instr_q, instr_d;
    logic [22:0]     addr_q, addr_d;
    logic [15:0]     wdata_q, wdata_d;
    logic [15:0]     rdata_q, rdata_d;
    logic            terr_q, terr_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   own_q, own_d;
    logic [BW-1:0]   burst_q, burst_d;
    logic [TW-1:0]   tmr_q, tmr_d;

    logic            found;
    logic [PW-1:0]   win;

    // First requester at or after the pointer, wrapping around.
    always_comb begin : pick
        int j;
        j     = 0;
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(ptr_q) + k;
            if (j >= NREQ) j = j - NREQ;
            if (!found && bus.req[j]) begin
                found = 1'b1;
                win   = PW'(j);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        latch_d = 1'b0;
        instr_d = instr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        terr_d  = terr_q;
        ptr_d   = ptr_q;
        own_d   = own_q;
        burst_d = burst_q;
        tmr_d   = tmr_q;
        case (state_q)
            S_IDLE: begin
                if (bus.ram_ready && found) begin
                    state_d      = S_ISSUE;
                    gnt_d        = '0;
                    gnt_d[win]   = 1'b1;
                    own_d        = win;
                    instr_d      = bus.req_we[win];
                    addr_d       = bus.req_addr[23*win +: 23];
                    wdata_d      = bus.req_wdata[16*win +: 16];
                    latch_d      = 1'b1;
                    // A grant to someone other than the burst holder starts a fresh burst.
                    if (win != ptr_q) burst_d = '0;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT_BUSY;
                tmr_d   = '0;
            end
            S_WAIT_BUSY: begin
                if (!bus.ram_ready) begin
                    state_d = S_WAIT_DONE;
                end else if (tmr_q == TW'(BUSY_TIMEOUT - 1)) begin
                    terr_d  = 1'b1;
                    done_d  = gnt_q;
                    state_d = S_DONE;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            S_WAIT_DONE: begin
                if (bus.ram_ready) begin
                    if (!instr_q) rdata_d = bus.ram_rdata;
                    done_d  = gnt_q;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                gnt_d   = '0;
                state_d = S_IDLE;
                if (int'(burst_q) + 1 < MAX_BURST) begin
                    burst_d = burst_q + BW'(1);
                    ptr_d   = own_q;
                end else begin
                    burst_d = '0;
                    ptr_d   = (own_q == PW'(NREQ - 1)) ? '0 : own_q + PW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            done_q  <= '0;
            latch_q <= 1'b0;
            instr_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            terr_q  <= 1'b0;
            ptr_q   <= '0;
            own_q   <= '0;
            burst_q <= '0;
            tmr_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            latch_q <= latch_d;
            instr_q <= instr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            terr_q  <= terr_d;
            ptr_q   <= ptr_d;
            own_q   <= own_d;
            burst_q <= burst_d;
            tmr_q   <= tmr_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.done      = done_q;
    assign bus.rdata     = rdata_q;
    assign bus.ram_instr = instr_q;
    assign bus.ram_latch = latch_q;
    assign bus.ram_addr  = addr_q;
    assign bus.ram_wdata = wdata_q;
    assign timeout_err   = terr_q;
endmodule
